// File: rtl/sop_pkg.sv
// Shared definitions for the sum-of-products truth-table unit.
// Holds the controller state encoding and the legal range of the
// function-input count N.
package sop_pkg;

    // Controller states. busy is derived as (state != IDLE).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } sop_state_t;

    // Supported number of function inputs.
    localparam int N_MIN = 2;
    localparam int N_MAX = 6;

endpackage

// File: rtl/sop_tt_reg.sv
// Truth-table storage for sop_table_unit.
// Holds the 2^N-bit table, the serial load counter and the tt_ready flag.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears table, count, tt_ready)
//   wr_en      : write wr_bit into the table this cycle
//   wr_first   : this write starts a new load (index 0, clears tt_ready)
//   wr_bit     : serial table bit
//   rd_addr    : combinational read address
//   rd_bit     : tt[rd_addr]
//   tt_ready   : a complete table has been loaded
//   wr_last    : the current write stores the final bit (index 2^N-1)
module sop_tt_reg #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         wr_first,
    input  logic         wr_bit,
    input  logic [N-1:0] rd_addr,
    output logic         rd_bit,
    output logic         tt_ready,
    output logic         wr_last
);

    localparam int TT = 1 << N;
    localparam logic [N-1:0] LAST_IDX = {N{1'b1}};

    logic [TT-1:0] tt_bits;
    logic [N-1:0]  cnt;
    logic [N-1:0]  wr_idx;

    // A fresh load always restarts at minterm 0 regardless of the old count.
    assign wr_idx  = wr_first ? '0 : cnt;
    assign wr_last = wr_en && !wr_first && (cnt == LAST_IDX);
    assign rd_bit  = tt_bits[rd_addr];

    // The count wraps to 0 after the last bit; tt_ready alone marks completeness.
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_bits  <= '0;
            cnt      <= '0;
            tt_ready <= 1'b0;
        end else if (wr_en) begin
            tt_bits[wr_idx] <= wr_bit;
            cnt             <= wr_idx + N'(1);
            if (wr_first)
                tt_ready <= 1'b0;
            else if (cnt == LAST_IDX)
                tt_ready <= 1'b1;
        end
    end

endmodule

// File: rtl/sop_table_unit.sv
// Truth-table driven boolean function unit.
// A 2^N-bit table is loaded serially (minterm 0 first). Once loaded, the
// unit answers single evaluations s = tt[x] with one cycle of latency, or
// sweeps all 2^N combinations one per cycle while counting true minterms.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   load_en      : load_bit is valid this cycle
//   load_bit     : serial table bit
//   start        : request a full sweep
//   eval_en      : request evaluation of x
//   x            : input vector, x[N-1] is the MSB variable
//   s            : registered function output (holds outside valid cycles)
//   s_valid      : s is a single-evaluation result
//   sweep_valid  : s/sweep_idx hold a sweep entry
//   sweep_idx    : combination producing s during a sweep
//   ones_cnt     : true-minterm count of the current/last sweep
//   done         : one-cycle pulse after the last sweep entry
//   tt_ready     : complete table loaded
//   busy         : state is LOAD, SWEEP or DONE
//
// Handshake: there is no back-pressure. A request (load_en, start, eval_en)
// is accepted only in the state that can act on it and otherwise dropped;
// each output valid (s_valid, sweep_valid, done) is high for exactly one
// cycle per result and the consumer must take it in that cycle.
module sop_table_unit
    import sop_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic         load_bit,
    input  logic         start,
    input  logic         eval_en,
    input  logic [N-1:0] x,
    output logic         s,
    output logic         s_valid,
    output logic         sweep_valid,
    output logic [N-1:0] sweep_idx,
    output logic [N:0]   ones_cnt,
    output logic         done,
    output logic         tt_ready,
    output logic         busy
);

    localparam logic [N-1:0] LAST_IDX = {N{1'b1}};

    sop_state_t   state, state_next;
    logic         s_next, s_valid_next, sweep_valid_next, done_next;
    logic [N-1:0] sweep_idx_next;
    logic [N:0]   ones_next;

    logic         wr_en, wr_first, wr_last;
    logic [N-1:0] rd_addr;
    logic         rd_bit;

    assign busy     = (state != IDLE);
    assign wr_en    = load_en && ((state == IDLE) || (state == LOAD));
    assign wr_first = (state == IDLE);

    sop_tt_reg #(.N(N)) u_tt (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_first (wr_first),
        .wr_bit   (load_bit),
        .rd_addr  (rd_addr),
        .rd_bit   (rd_bit),
        .tt_ready (tt_ready),
        .wr_last  (wr_last)
    );

    // Outputs are registered, so the read looks one entry ahead: entry 0 is
    // fetched in the cycle start is accepted, entry k+1 while entry k shows.
    always_comb begin
        rd_addr = x;
        if (state == SWEEP)
            rd_addr = sweep_idx + N'(1);
        else if (start)
            rd_addr = '0;
    end

    always_comb begin
        state_next       = state;
        s_next           = s;
        s_valid_next     = 1'b0;
        sweep_valid_next = 1'b0;
        sweep_idx_next   = sweep_idx;
        ones_next        = ones_cnt;
        done_next        = 1'b0;
        case (state)
            IDLE: begin
                if (load_en) begin
                    state_next = LOAD;
                end else if (start && tt_ready) begin
                    state_next       = SWEEP;
                    sweep_valid_next = 1'b1;
                    sweep_idx_next   = '0;
                    s_next           = rd_bit;
                    ones_next        = {N'(0), rd_bit};
                end else if (eval_en && tt_ready) begin
                    s_next       = rd_bit;
                    s_valid_next = 1'b1;
                end
            end
            LOAD: begin
                if (wr_last)
                    state_next = IDLE;
            end
            SWEEP: begin
                if (sweep_idx == LAST_IDX) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    sweep_valid_next = 1'b1;
                    sweep_idx_next   = sweep_idx + N'(1);
                    s_next           = rd_bit;
                    ones_next        = ones_cnt + {N'(0), rd_bit};
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s           <= 1'b0;
            s_valid     <= 1'b0;
            sweep_valid <= 1'b0;
            sweep_idx   <= '0;
            ones_cnt    <= '0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            s           <= s_next;
            s_valid     <= s_valid_next;
            sweep_valid <= sweep_valid_next;
            sweep_idx   <= sweep_idx_next;
            ones_cnt    <= ones_next;
            done        <= done_next;
        end
    end

endmodule

// File: tb/tb_sop_table_unit.sv
// Directed bench for sop_table_unit: an N=4 instance for the main scenarios
// and an N=6 instance for the all-ones / all-zeros sweep boundaries.
module tb_sop_table_unit;

    logic clk;
    logic rst;

    // N=4 instance signals
    logic       load_en, load_bit, start, eval_en;
    logic [3:0] x;
    logic       s, s_valid, sweep_valid, done, tt_ready, busy;
    logic [3:0] sweep_idx;
    logic [4:0] ones_cnt;

    // N=6 instance signals
    logic       load_en6, load_bit6, start6, eval_en6;
    logic [5:0] x6;
    logic       s6, s_valid6, sweep_valid6, done6, tt_ready6, busy6;
    logic [5:0] sweep_idx6;
    logic [6:0] ones_cnt6;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] TBL = 16'h8C6B;

    sop_table_unit #(.N(4)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_bit(load_bit),
        .start(start), .eval_en(eval_en), .x(x), .s(s), .s_valid(s_valid),
        .sweep_valid(sweep_valid), .sweep_idx(sweep_idx), .ones_cnt(ones_cnt),
        .done(done), .tt_ready(tt_ready), .busy(busy)
    );

    sop_table_unit #(.N(6)) dut6 (
        .clk(clk), .rst(rst), .load_en(load_en6), .load_bit(load_bit6),
        .start(start6), .eval_en(eval_en6), .x(x6), .s(s6), .s_valid(s_valid6),
        .sweep_valid(sweep_valid6), .sweep_idx(sweep_idx6), .ones_cnt(ones_cnt6),
        .done(done6), .tt_ready(tt_ready6), .busy(busy6)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        total++;
        if ({s, s_valid, sweep_valid, sweep_idx, ones_cnt, done, tt_ready, busy} !== 16'h0) begin
            bad++;
            $display("FAIL reset_n4: got %b expected all zero",
                     {s, s_valid, sweep_valid, sweep_idx, ones_cnt, done, tt_ready, busy});
        end
        total++;
        if ({s6, s_valid6, sweep_valid6, sweep_idx6, ones_cnt6, done6, tt_ready6, busy6} !== 20'h0) begin
            bad++;
            $display("FAIL reset_n6: got %b expected all zero",
                     {s6, s_valid6, sweep_valid6, sweep_idx6, ones_cnt6, done6, tt_ready6, busy6});
        end
    endtask

    // start and eval before any table is loaded are dropped
    task automatic test_unloaded();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({sweep_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL unloaded_start: sweep_valid,busy=%b expected 00", {sweep_valid, busy});
        end
        eval_en = 1'b1;
        x = 4'd3;
        tick();
        eval_en = 1'b0;
        total++;
        if (s_valid !== 1'b0) begin
            bad++;
            $display("FAIL unloaded_eval: s_valid=%b expected 0", s_valid);
        end
    endtask

    // load 0x8C6B; start raised with the first bit must be dropped
    task automatic test_load();
        for (int i = 0; i < 16; i++) begin
            load_en  = 1'b1;
            load_bit = TBL[i];
            start    = (i == 0);
            tick();
            load_en = 1'b0;
            start   = 1'b0;
            if (i == 0) begin
                total++;
                if ({busy, sweep_valid} !== 2'b10) begin
                    bad++;
                    $display("FAIL load_start_drop: busy,sweep_valid=%b expected 10", {busy, sweep_valid});
                end
            end
            if (i == 8) begin
                tick();  // idle gap inside LOAD
                total++;
                if ({busy, tt_ready} !== 2'b10) begin
                    bad++;
                    $display("FAIL load_gap: busy,tt_ready=%b expected 10", {busy, tt_ready});
                end
            end
            if (i < 15) begin
                total++;
                if ({busy, tt_ready} !== 2'b10) begin
                    bad++;
                    $display("FAIL load_busy bit %0d: busy,tt_ready=%b expected 10", i, {busy, tt_ready});
                end
            end
        end
        total++;
        if ({busy, tt_ready} !== 2'b01) begin
            bad++;
            $display("FAIL load_complete: busy,tt_ready=%b expected 01", {busy, tt_ready});
        end
    endtask

    task automatic test_sweep();
        int exp_ones;
        exp_ones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_ones += int'(TBL[i]);
            total++;
            if ({sweep_valid, sweep_idx, s, ones_cnt, done} !== {1'b1, 4'(i), TBL[i], 5'(exp_ones), 1'b0}) begin
                bad++;
                $display("FAIL sweep_entry %0d: valid=%b idx=%0d s=%b ones=%0d done=%b expected 1 %0d %b %0d 0",
                         i, sweep_valid, sweep_idx, s, ones_cnt, done, i, TBL[i], exp_ones);
            end
            tick();
        end
        total++;
        if ({done, sweep_valid, busy, ones_cnt} !== {3'b101, 5'd8}) begin
            bad++;
            $display("FAIL sweep_done: done=%b valid=%b busy=%b ones=%0d expected 1 0 1 8",
                     done, sweep_valid, busy, ones_cnt);
        end
        tick();
        total++;
        if ({done, busy, ones_cnt} !== {2'b00, 5'd8}) begin
            bad++;
            $display("FAIL sweep_after: done=%b busy=%b ones=%0d expected 0 0 8", done, busy, ones_cnt);
        end
    endtask

    task automatic test_back_to_back_eval();
        eval_en = 1'b1;
        x = 4'b1010;
        tick();
        x = 4'b0010;
        total++;
        if ({s_valid, s} !== 2'b11) begin
            bad++;
            $display("FAIL eval_1010: s_valid,s=%b expected 11", {s_valid, s});
        end
        tick();
        eval_en = 1'b0;
        total++;
        if ({s_valid, s} !== 2'b10) begin
            bad++;
            $display("FAIL eval_0010: s_valid,s=%b expected 10", {s_valid, s});
        end
        x = 4'b1111;
        tick();
        total++;
        if ({s_valid, s} !== 2'b00) begin
            bad++;
            $display("FAIL eval_hold: s_valid,s=%b expected 00", {s_valid, s});
        end
    endtask

    task automatic test_reset_mid_sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        total++;
        if ({sweep_valid, sweep_idx} !== 5'b1_0111) begin
            bad++;
            $display("FAIL abort_at7: valid,idx=%b expected 10111", {sweep_valid, sweep_idx});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({s, s_valid, sweep_valid, sweep_idx, ones_cnt, done, tt_ready, busy} !== 16'h0) begin
            bad++;
            $display("FAIL abort_reset: got %b expected all zero",
                     {s, s_valid, sweep_valid, sweep_idx, ones_cnt, done, tt_ready, busy});
        end
        tick();
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++;
            $display("FAIL abort_no_done: done,busy=%b expected 00", {done, busy});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({sweep_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL abort_start_ignored: sweep_valid,busy=%b expected 00", {sweep_valid, busy});
        end
        eval_en = 1'b1;
        x = 4'd0;
        tick();
        eval_en = 1'b0;
        total++;
        if (s_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_eval_ignored: s_valid=%b expected 0", s_valid);
        end
    endtask

    task automatic load6(input logic v);
        for (int i = 0; i < 64; i++) begin
            load_en6  = 1'b1;
            load_bit6 = v;
            tick();
        end
        load_en6 = 1'b0;
    endtask

    task automatic sweep6(input int exp_ones, input string tag);
        int n;
        int guard;
        n = 0;
        guard = 0;
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        while (!done6 && guard < 100) begin
            if (sweep_valid6) n++;
            tick();
            guard++;
        end
        total++;
        if (done6 !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: done=%b after %0d cycles expected 1", tag, done6, guard);
        end
        total++;
        if (n !== 64) begin
            bad++;
            $display("FAIL %s_entries: got %0d expected 64", tag, n);
        end
        total++;
        if (ones_cnt6 !== 7'(exp_ones)) begin
            bad++;
            $display("FAIL %s_ones: got %0d expected %0d", tag, ones_cnt6, exp_ones);
        end
        tick();
    endtask

    task automatic test_n6_bounds();
        load6(1'b1);
        total++;
        if (tt_ready6 !== 1'b1) begin
            bad++;
            $display("FAIL n6_ready: tt_ready=%b expected 1", tt_ready6);
        end
        sweep6(64, "n6_ones");
        load6(1'b0);
        sweep6(0, "n6_zeros");
    endtask

    initial begin
        rst = 1'b1;
        load_en = 1'b0;  load_bit = 1'b0;  start = 1'b0;  eval_en = 1'b0;  x = '0;
        load_en6 = 1'b0; load_bit6 = 1'b0; start6 = 1'b0; eval_en6 = 1'b0; x6 = '0;
        test_reset();
        test_unloaded();
        test_load();
        test_sweep();
        test_back_to_back_eval();
        test_reset_mid_sweep();
        test_n6_bounds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sop_table_unit.md
SOP_TABLE_UNIT -- requirements
Module: sop_table_unit

Interface
REQ-001 Parameter N, default 4, meaning number of function inputs; legal range 2..6; truth table width TT = 2^N bits.
REQ-002 clk  in  1  single clock for the block; all state updates on the rising edge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 load_en  in  1  a truth-table bit is presented on load_bit this cycle.
REQ-005 load_bit  in  1  serial truth-table bit; the first bit is minterm 0, the last bit is minterm TT-1.
REQ-006 start  in  1  request a full sweep of all 2^N input combinations.
REQ-007 eval_en  in  1  request a single evaluation of input vector x.
REQ-008 x  in  N  input vector for single evaluation; x[N-1] is the most significant variable.
REQ-009 s  out  1  registered function output.
REQ-010 s_valid  out  1  s holds a single-evaluation result this cycle.
REQ-011 sweep_valid  out  1  s and sweep_idx hold one sweep entry this cycle.
REQ-012 sweep_idx  out  N  input combination that produced s during a sweep.
REQ-013 ones_cnt  out  N+1  number of true minterms counted by the current or last sweep.
REQ-014 done  out  1  one-cycle pulse marking the end of a sweep.
REQ-015 tt_ready  out  1  a complete truth table is loaded.
REQ-016 busy  out  1  the block is in LOAD, SWEEP or DONE.

Function
REQ-017 States SHALL be IDLE, LOAD, SWEEP and DONE; busy = (state != IDLE).
REQ-018 Priority in IDLE: load_en > start > eval_en; lower-priority requests in the same cycle are dropped.
REQ-019 IDLE with load_en: store load_bit at index 0, clear tt_ready, set load count to 1, go to LOAD.
REQ-020 LOAD: each load_en cycle stores load_bit at the current index and increments the count; cycles without load_en hold state.
REQ-021 LOAD: the cycle that stores bit TT-1 sets tt_ready=1 the next cycle and returns to IDLE.
REQ-022 LOAD: start and eval_en are ignored.
REQ-023 IDLE with eval_en and tt_ready=1: s = tt[x] and s_valid=1 in the next cycle (latency 1); s_valid is high for one cycle per request.
REQ-024 eval_en with tt_ready=0 is ignored: s_valid stays 0.
REQ-025 Back-to-back eval_en SHALL give one result per cycle.
REQ-026 IDLE with start and tt_ready=1: clear ones_cnt and go to SWEEP with index 0; start with tt_ready=0 is ignored.
REQ-027 SWEEP: each cycle drives sweep_valid=1, sweep_idx=index, s=tt[index], and ones_cnt += tt[index].
REQ-028 SWEEP: the first entry appears the cycle after start is accepted.
REQ-029 SWEEP: index TT-1 is the last entry; the next cycle is DONE, with no wrap to 0.
REQ-030 DONE: lasts one cycle with done=1, sweep_valid=0 and final ones_cnt (0..2^N); then IDLE.
REQ-031 ones_cnt SHALL hold its value until the next accepted start or rst.
REQ-032 SWEEP and DONE: load_en, start and eval_en are ignored.
REQ-033 Outside its valid cycles, s SHALL hold its last value.

Reset
REQ-034 When rst=1 at a clock edge: state goes to IDLE and these outputs are 0 the next cycle: s, s_valid, sweep_valid, sweep_idx, ones_cnt, done, tt_ready, busy.
REQ-035 rst also clears the truth table and the load count; rst has priority over all inputs.
REQ-036 rst during LOAD or SWEEP SHALL abort the operation with no done pulse; a new load is required before sweep or eval.

Structure
REQ-037 Shared package sop_pkg SHALL hold the state enum (IDLE, LOAD, SWEEP, DONE) and the N_MIN=2 and N_MAX=6 constants.
REQ-038 Sub-module sop_tt_reg SHALL hold the TT-bit storage, the load counter and tt_ready; it provides a combinational read port tt[addr].
REQ-039 The state machine, sweep counter and ones_cnt SHALL live in sop_table_unit.

Verification
REQ-040 N=4: load 16 bits giving table 0x8C6B (minterms 0,1,3,5,6,10,11,15) -> tt_ready=1 one cycle after the 16th bit; busy=1 throughout load.
REQ-041 After REQ-040: start -> 16 consecutive sweep_valid cycles, idx 0..15, s=1 exactly at 0,1,3,5,6,10,11,15; done pulse; ones_cnt=8.
REQ-042 eval_en with x=4'b1010, then x=4'b0010 on consecutive cycles -> s=1 then s=0, s_valid=1 on both following cycles.
REQ-043 start and eval_en before any load -> no sweep_valid, no s_valid; load_en plus start in the same IDLE cycle -> LOAD entered and start dropped.
REQ-044 rst asserted at sweep index 7 -> next cycle all outputs 0 and tt_ready=0, no done pulse; a subsequent start is ignored until reload.
REQ-045 N=6 with an all-ones table -> sweep of 64 entries, ones_cnt=64 (7-bit); with an all-zeros table -> ones_cnt=0.
